// File: rtl/booth_mul_seq_if.sv
// Handshake and operand/result bundle for booth_mul_seq.
//   start        : request pulse, sampled only while the sequencer is idle
//   multiplicand : signed operand M, captured on an accepted start
//   multiplier   : signed operand Q, captured on an accepted start
//   ready        : sequencer idle and able to accept a start
//   busy         : multiplication in progress
//   done         : single-cycle pulse marking a fresh product
//   product      : signed 2*WIDTH-bit result, held until the next accepted start
// master: the requester (drives start/operands). slave: the multiplier.
interface booth_mul_seq_if #(
    parameter int WIDTH = 4
);
    logic                 start;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 ready;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, multiplicand, multiplier,
        input  ready, busy, done, product
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output ready, busy, done, product
    );
endinterface

// File: rtl/booth_mul_seq.sv
// Multi-cycle signed multiplier using radix-2 Booth recoding.
// One add, subtract or pass per cycle followed by an arithmetic right shift
// of {A,Q,q_1}; WIDTH shift cycles per operation, then a one-cycle done pulse.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, discards any operation in flight
//   bus   : booth_mul_seq_if slave modport (start/operands in, status/product out)
//
// state | meaning
// IDLE  | ready=1, waiting for start; product holds last result
// RUN   | busy=1, one Booth step per edge, WIDTH edges
// DONE  | done=1 for one cycle, product freshly valid
module booth_mul_seq #(
    parameter int WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    booth_mul_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH:0]     a_r;        // one guard bit so (-2^(W-1))^2 cannot overflow
    logic [WIDTH-1:0]   q_r;
    logic               q_1_r;
    logic [WIDTH-1:0]   m_r;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] product_r;
    logic               ready_r;
    logic               busy_r;
    logic               done_r;

    logic [1:0]         op;
    logic               sub;
    logic [WIDTH:0]     m_ext;
    logic [WIDTH:0]     addend;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     t;
    logic [2*WIDTH+1:0] shifted;

    // Booth step: 01 adds M, 10 subtracts M as A + ~M + 1, 00/11 pass A.
    always_comb begin
        op      = {q_r[0], q_1_r};
        sub     = (op == 2'b10);
        m_ext   = {m_r[WIDTH-1], m_r};
        addend  = m_ext ^ {(WIDTH+1){sub}};
        sum     = a_r + addend + {{WIDTH{1'b0}}, sub};
        t       = ((op == 2'b01) || (op == 2'b10)) ? sum : a_r;
        // Arithmetic shift of {T,Q,q_1}: bits [2W+1:W+1] -> A, [W:1] -> Q, [0] -> q_1.
        shifted = {t[WIDTH], t, q_r};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_r       <= '0;
            q_r       <= '0;
            q_1_r     <= 1'b0;
            m_r       <= '0;
            count     <= '0;
            product_r <= '0;
            ready_r   <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_r     <= '0;
                        q_r     <= bus.multiplier;
                        q_1_r   <= 1'b0;
                        m_r     <= bus.multiplicand;
                        count   <= CW'(WIDTH);
                        state   <= RUN;
                        ready_r <= 1'b0;
                        busy_r  <= 1'b1;
                    end
                end
                RUN: begin
                    a_r   <= shifted[2*WIDTH+1:WIDTH+1];
                    q_r   <= shifted[WIDTH:1];
                    q_1_r <= shifted[0];
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        // Low WIDTH bits of the new A plus the new Q form the product.
                        product_r <= shifted[2*WIDTH:1];
                        state     <= DONE;
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready   = ready_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.product = product_r;
endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed bench for booth_mul_seq with WIDTH=4; hand-computed products plus
// a signed reference sweep over all operand pairs.
module tb_booth_mul_seq;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    booth_mul_seq_if #(.WIDTH(W)) bus();

    booth_mul_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one operation, measures edges from acceptance to done, checks
    // one-hot status each cycle, the product, and the return to ready.
    task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic [7:0] exp);
        int n;
        bus.multiplicand = a;
        bus.multiplier   = b;
        bus.start        = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 1;
        while (!bus.done && n < 20) begin
            chk({tag, "_busy"}, {13'd0, bus.ready, bus.busy, bus.done}, 16'b010);
            tick();
            n++;
        end
        chk({tag, "_lat"}, 16'(n), 16'd5);
        chk({tag, "_prod"}, {8'd0, bus.product}, {8'd0, exp});
        chk({tag, "_donest"}, {13'd0, bus.ready, bus.busy, bus.done}, 16'b001);
        tick();
        chk({tag, "_idle"}, {13'd0, bus.ready, bus.busy, bus.done}, 16'b100);
        chk({tag, "_hold"}, {8'd0, bus.product}, {8'd0, exp});
    endtask

    initial begin
        bus.start        = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;

        #2 rst_n = 1'b0;
        #1;
        chk("rst_status", {13'd0, bus.ready, bus.busy, bus.done}, 16'b100);
        chk("rst_product", {8'd0, bus.product}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run_op("mul_3x5", 4'd3, 4'd5, 8'h0F);
        run_op("mul_m8xm8", 4'h8, 4'h8, 8'h40);
        run_op("mul_7xm8", 4'h7, 4'h8, 8'hC8);
        run_op("mul_m1xm1", 4'hF, 4'hF, 8'h01);
        run_op("mul_0xm7", 4'h0, 4'h9, 8'h00);

        // start held high: second request only taken once back in IDLE.
        bus.multiplicand = 4'd2;
        bus.multiplier   = 4'd3;
        bus.start        = 1'b1;
        tick();
        bus.multiplicand = 4'd4;
        bus.multiplier   = 4'd4;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("held_run_busy", {15'd0, bus.busy}, 16'd1);
        end
        tick();
        chk("held_first_done", {15'd0, bus.done}, 16'd1);
        chk("held_first_prod", {8'd0, bus.product}, 16'h0006);
        tick();
        chk("held_back_idle", {15'd0, bus.ready}, 16'd1);
        tick();
        chk("held_second_accept", {15'd0, bus.busy}, 16'd1);
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("held_second_done", {15'd0, bus.done}, 16'd1);
        chk("held_second_prod", {8'd0, bus.product}, 16'h0010);
        tick();

        // Operands wiggle during RUN; captured 6 x -3 must win.
        bus.multiplicand = 4'd6;
        bus.multiplier   = 4'hD;
        bus.start        = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.multiplicand = 4'($urandom_range(0, 15));
            bus.multiplier   = 4'($urandom_range(0, 15));
            tick();
        end
        chk("wiggle_done", {15'd0, bus.done}, 16'd1);
        chk("wiggle_prod", {8'd0, bus.product}, 16'h00EE);
        tick();

        // Asynchronous reset during RUN cycle 2.
        bus.multiplicand = 4'd7;
        bus.multiplier   = 4'd3;
        bus.start        = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_status", {13'd0, bus.ready, bus.busy, bus.done}, 16'b100);
        chk("arst_product", {8'd0, bus.product}, 16'h0000);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("arst_no_done", {15'd0, bus.done}, 16'd0);
        end
        run_op("mul_5x5", 4'd5, 4'd5, 8'h19);

        // Full sweep against a signed reference.
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                int sa, sb, p;
                sa = (i > 7) ? i - 16 : i;
                sb = (j > 7) ? j - 16 : j;
                p  = sa * sb;
                run_op("sweep", 4'(i), 4'(j), 8'(p));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/booth_mul_seq.md
Name: booth_mul_seq

Overview:
- Multi-cycle signed multiplier sequencer for the processor's multiply path.
- Computes a WIDTH x WIDTH two's-complement product using radix-2 Booth recoding.
- Performs at most one add or subtract per cycle, followed by an arithmetic right shift.
- The add/sub step follows the team add/sub convention: m=0 adds, m=1 subtracts via B^m with carry-in m.

Parameters:
- WIDTH, 4, operand width in bits; product is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- multiplicand  input  WIDTH  signed operand M; captured when start is accepted.
- multiplier  input  WIDTH  signed operand Q; captured when start is accepted.
- ready  output  1  high only in IDLE.
- busy  output  1  high in RUN.
- done  output  1  single-cycle pulse, high in DONE.
- product  output  2*WIDTH  signed result; holds its value until the next accepted start.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; A, Q, q_1, M, count and product = 0.
  - ready=1, busy=0, done=0.
  - Takes effect immediately, including mid-operation; the partial result is discarded.
- Registers:
  - A: WIDTH+1 bits, signed accumulator. The extra bit prevents overflow on (-2^(W-1)) x (-2^(W-1)).
  - Q: WIDTH bits. q_1: 1 bit. M: WIDTH bits, sign-extended to WIDTH+1 for the add/sub step.
  - count: clog2(WIDTH)+1 bits.
- IDLE:
  - On start=1 at an edge: A<=0, Q<=multiplier, q_1<=0, M<=multiplicand, count<=WIDTH, state<=RUN.
  - product is not cleared on start; it keeps the old result until DONE.
- RUN, each edge:
  - Select the operation from {Q[0],q_1}: 00/11 gives T=A; 01 gives T=A+M (m=0); 10 gives T=A-M (m=1).
  - Shift: {A,Q,q_1} <= arithmetic right shift by 1 of {T,Q,q_1}, replicating T's MSB.
  - count<=count-1.
  - If count==1 at this edge, state<=DONE.
  - Exactly WIDTH RUN cycles per operation.
- DONE:
  - product <= {A[WIDTH-1:0],Q}, registered on entry edge so it is valid while done=1.
  - done=1 for exactly one cycle; next edge state<=IDLE.
- Latency:
  - start accepted at edge k; RUN covers edges k+1..k+WIDTH.
  - done=1 and the new product are visible in the cycle after edge k+WIDTH (WIDTH+1 edges total).
  - Next start is accepted no earlier than edge k+WIDTH+2.
- Ignored stimulus:
  - start in RUN or DONE is ignored; there is no queueing.
  - Operand changes after acceptance have no effect.
- Arithmetic:
  - All add/sub operations are WIDTH+1-bit two's-complement; carry-out is discarded.
  - The result is exact for all 2^(2W) operand pairs; no overflow flag is required.
- Output decoding:
  - ready, busy and done are decoded from state only and are mutually exclusive.
  - Exactly one of them is high in every cycle after reset.

Test Plan:
- 3 x 5 (WIDTH=4): start one cycle -> busy for 4 cycles, then done pulse of 1 cycle with product=8'h0F, then ready=1.
- Signed corners: -8 x -8 -> 8'h40; 7 x -8 -> 8'hC8; -1 x -1 -> 8'h01; 0 x -7 -> 8'h00.
- start held high continuously with 2 x 3 then 4 x 4 on the operands:
  - First result 8'h06 arrives on the 5th edge after acceptance; start is ignored in RUN/DONE.
  - Second operation is accepted on the edge after returning to IDLE, giving 8'h10.
- Operands changed every cycle during RUN after accepting 6 x -3 -> product=8'hEE, unaffected.
- rst_n pulsed low asynchronously during RUN cycle 2:
  - Immediately state=IDLE, product=0, ready=1, done never pulses.
  - The next start with 5 x 5 yields 8'h19.
- Exhaustive sweep of all 256 operand pairs against a signed reference model; check latency is exactly 5 edges each.
